// File: rtl/lim_mem_initiator.sv
// Core-side initiator for a logic-in-memory controller: accepts one request,
// starts the memory, waits for completion or timeout, then returns one response.
module lim_mem_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [7:0]            lim_funct_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  mem_en_o,
  output logic                  mem_w_en_o,
  output logic [3:0]            mem_be_o,
  output logic [7:0]            mem_funct_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rdata_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_done_i,
  output logic                  busy_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [7:0]            r_funct;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_cap;
  logic                  r_mem_en;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_gnt;
  logic                  w_empty_wr;
  logic [DATA_WIDTH-1:0] w_final_cap;

  assign w_gnt       = data_req_i && (r_state == IDLE);
  assign w_empty_wr  = data_we_i && (data_be_i == 4'b0000);
  // Data arriving together with done must make it into the response.
  assign w_final_cap = mem_rdata_valid_i ? mem_rdata_i : r_cap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_funct  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cap    <= '0;
      r_mem_en <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: if (w_gnt) begin
          r_we    <= data_we_i;
          r_be    <= data_be_i;
          r_funct <= lim_funct_i;
          r_addr  <= data_addr_i;
          r_wdata <= data_wdata_i;
          r_cap   <= '0;
          if (w_empty_wr) begin
            r_state  <= RESP;
            r_rvalid <= 1'b1;
          end else begin
            r_state  <= ISSUE;
            r_mem_en <= 1'b1;
          end
        end
        ISSUE: begin
          r_cnt   <= CW'(TIMEOUT_CYCLES);
          r_state <= WAIT;
        end
        WAIT: begin
          if (mem_rdata_valid_i) r_cap <= mem_rdata_i;
          if (mem_done_i) begin
            r_state  <= RESP;
            r_rvalid <= 1'b1;
            r_rdata  <= r_we ? '0 : w_final_cap;
          end else if (r_cnt == '0) begin
            r_state  <= RESP;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign data_err_o    = r_err;
  assign mem_en_o      = r_mem_en;
  assign mem_w_en_o    = r_we;
  assign mem_be_o      = r_be;
  assign mem_funct_o   = r_funct;
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign busy_o        = (r_state != IDLE);

endmodule
